// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
package rf_wb_arbiter_pkg;

   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int ENTRY_W  = REG_W + DATA_W;

   // Wide enough to hold a popcount of every register (0..NUM_REGS).
   localparam int PCNT_W   = $clog2(NUM_REGS) + 1;

   // One MDU result waiting for the write port.
   typedef struct packed {
      logic [REG_W-1:0]  wn;
      logic [DATA_W-1:0] d;
   } fifo_entry_t;

   // Number of registers currently marked as awaiting an MDU result.
   function automatic logic [PCNT_W-1:0] pend_count(input logic [NUM_REGS-1:0] pend);
      logic [PCNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         n = n + PCNT_W'(pend[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// DEPTH-entry synchronous FIFO holding MDU results until they win the write port.
// Handshake: push is accepted only while !full, pop is honoured only while !empty;
// the head is valid whenever empty is low and is removed at the posedge of a pop.
module rf_wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic               full,
   output logic               empty,
   output logic [ENTRY_W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
   logic [ENTRY_W-1:0]   mem_q [DEPTH];
   logic [ENTRY_W-1:0]   mem_d [DEPTH];

   // Status flags and head-of-queue read.
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      head  = mem_q[rd_ptr_q[PTR_W-1:0]];
   end

   // Next-state: write at the tail on an accepted push, advance the head on a pop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
         wr_ptr_d                   = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Storage and pointer registers; clearing discards every queued entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owner of the single register-file write port. The pipeline WB stage has
// priority; MDU results queue in a small FIFO and are written when WB is idle,
// or forcibly (WB hold bubble) once the queue has been starved long enough.
// A per-register pending scoreboard tracks issued MDU ops for ID-stage hazards.
//
// Handshakes: an MDU result is transferred on md_valid & md_ready at posedge;
// an MDU op is issued on iss_valid, which the ID stage raises only with iss_ok.
// wb_hold is a same-cycle command: the WB write is not performed while it is high.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        Clk,
   input  logic        Clrn,
   input  logic        wb_we,
   input  logic [4:0]  wb_wn,
   input  logic [31:0] wb_d,
   output logic        wb_hold,
   input  logic        md_valid,
   input  logic [4:0]  md_wn,
   input  logic [31:0] md_d,
   output logic        md_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_wn,
   output logic        iss_ok,
   input  logic [4:0]  id_ra,
   input  logic [4:0]  id_rb,
   input  logic [4:0]  id_wn,
   output logic        id_stall,
   output logic        rf_we,
   output logic [4:0]  rf_wn,
   output logic [31:0] rf_d
);

   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [PCNT_W-1:0] DEPTH_LIM  = PCNT_W'(DEPTH);

   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic [ENTRY_W-1:0]  fifo_push_data;
   logic [ENTRY_W-1:0]  fifo_head_raw;
   fifo_entry_t         fifo_head;
   fifo_entry_t         md_entry;

   logic                wb_win;
   logic [CNT_W-1:0]    starve_q, starve_d;
   logic [NUM_REGS-1:0] pend_q, pend_d;

   rf_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (Clk),
      .rst_n     (Clrn),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head_raw)
   );

   // Pack the incoming MDU result and unpack the queue head.
   always_comb begin
      md_entry.wn    = md_wn;
      md_entry.d     = md_d;
      fifo_push_data = md_entry;
      fifo_head      = fifo_entry_t'(fifo_head_raw);
   end

   // Write-port select: WB first unless the queue has starved, then the FIFO head.
   // Everything is qualified with Clrn so no write escapes while reset is asserted.
   always_comb begin
      wb_hold   = Clrn && !fifo_empty && (starve_q == STARVE_LIM);
      wb_win    = Clrn && !wb_hold && wb_we && (wb_wn != '0);
      fifo_pop  = Clrn && !wb_win && !fifo_empty;
      md_ready  = !fifo_full;
      fifo_push = md_valid && md_ready;
      rf_we     = 1'b0;
      rf_wn     = '0;
      rf_d      = '0;
      if (wb_win) begin
         rf_we = 1'b1;
         rf_wn = wb_wn;
         rf_d  = wb_d;
      end else if (fifo_pop && (fifo_head.wn != '0)) begin
         // A head aimed at r0 still pops, it just never reaches the regfile.
         rf_we = 1'b1;
         rf_wn = fifo_head.wn;
         rf_d  = fifo_head.d;
      end
   end

   // Starvation counter: counts cycles a waiting result loses to WB, clears on pop.
   always_comb begin
      starve_d = starve_q;
      if (fifo_pop) begin
         starve_d = '0;
      end else if (!fifo_empty && wb_win && (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Pending scoreboard: clear on pop of that register, then set on issue so a
   // same-cycle issue to the register being retired keeps it pending.
   always_comb begin
      pend_d = pend_q;
      if (fifo_pop) begin
         pend_d[fifo_head.wn] = 1'b0;
      end
      if (iss_valid && (iss_wn != '0)) begin
         pend_d[iss_wn] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // Hazard outputs. pend_q[0] is never set, so r0 cannot cause a stall.
   // Limiting outstanding ops to DEPTH guarantees every result finds FIFO room.
   always_comb begin
      id_stall = pend_q[id_ra] | pend_q[id_rb] | pend_q[id_wn];
      iss_ok   = !pend_q[iss_wn] && (pend_count(pend_q) < DEPTH_LIM);
   end

   // State registers; reset drops all pending marks and the starvation history.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         starve_q <= '0;
         pend_q   <= '0;
      end else begin
         starve_q <= starve_d;
         pend_q   <= pend_d;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: fixed vector table, hand-written corner sequences,
// then random traffic against a queue-based reference model.
module tb_rf_wb_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   typedef struct packed {
      logic        wb_we;
      logic [4:0]  wb_wn;
      logic [31:0] wb_d;
      logic        md_valid;
      logic [4:0]  md_wn;
      logic [31:0] md_d;
      logic        iss_valid;
      logic [4:0]  iss_wn;
      logic [4:0]  id_ra;
      logic [4:0]  id_rb;
      logic [4:0]  id_wn;
   } vin_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  wn;
      logic [31:0] d;
      logic        hold;
      logic        ready;
      logic        ok;
      logic        stall;
   } vex_t;

   typedef struct {
      vin_t vi;
      vex_t ve;
   } vec_t;

   // ---------------- clock / reset / DUT ----------------
   logic        Clk, Clrn;
   logic        wb_we, md_valid, iss_valid;
   logic [4:0]  wb_wn, md_wn, iss_wn, id_ra, id_rb, id_wn;
   logic [31:0] wb_d, md_d;
   logic        wb_hold, md_ready, iss_ok, id_stall, rf_we;
   logic [4:0]  rf_wn;
   logic [31:0] rf_d;

   int total;
   int bad;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   rf_wb_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .Clk       (Clk),
      .Clrn      (Clrn),
      .wb_we     (wb_we),
      .wb_wn     (wb_wn),
      .wb_d      (wb_d),
      .wb_hold   (wb_hold),
      .md_valid  (md_valid),
      .md_wn     (md_wn),
      .md_d      (md_d),
      .md_ready  (md_ready),
      .iss_valid (iss_valid),
      .iss_wn    (iss_wn),
      .iss_ok    (iss_ok),
      .id_ra     (id_ra),
      .id_rb     (id_rb),
      .id_wn     (id_wn),
      .id_stall  (id_stall),
      .rf_we     (rf_we),
      .rf_wn     (rf_wn),
      .rf_d      (rf_d)
   );

   // ---------------- helpers ----------------
   function automatic vin_t mk_in(input logic a_we, input logic [4:0] a_wn, input logic [31:0] a_d,
                                  input logic m_v, input logic [4:0] m_wn, input logic [31:0] m_d,
                                  input logic i_v, input logic [4:0] i_wn,
                                  input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wn);
      vin_t v;
      v.wb_we = a_we; v.wb_wn = a_wn; v.wb_d = a_d;
      v.md_valid = m_v; v.md_wn = m_wn; v.md_d = m_d;
      v.iss_valid = i_v; v.iss_wn = i_wn;
      v.id_ra = ra; v.id_rb = rb; v.id_wn = wn;
      return v;
   endfunction

   function automatic vex_t mk_ex(input logic we, input logic [4:0] wn, input logic [31:0] d,
                                  input logic hold, input logic ready, input logic ok, input logic stall);
      vex_t e;
      e.we = we; e.wn = wn; e.d = d;
      e.hold = hold; e.ready = ready; e.ok = ok; e.stall = stall;
      return e;
   endfunction

   function automatic vin_t idle_in(input logic [4:0] ra);
      return mk_in(0, 0, 0, 0, 0, 0, 0, 0, ra, 0, 0);
   endfunction

   task automatic drive(input vin_t v);
      wb_we = v.wb_we; wb_wn = v.wb_wn; wb_d = v.wb_d;
      md_valid = v.md_valid; md_wn = v.md_wn; md_d = v.md_d;
      iss_valid = v.iss_valid; iss_wn = v.iss_wn;
      id_ra = v.id_ra; id_rb = v.id_rb; id_wn = v.id_wn;
   endtask

   // rf_wn / rf_d are only meaningful while rf_we is expected high.
   task automatic check(input string name, input vex_t e);
      logic [41:0] act, req;
      act = {rf_we, e.we ? rf_wn : 5'd0, e.we ? rf_d : 32'd0, wb_hold, md_ready, iss_ok, id_stall};
      req = {e.we, e.we ? e.wn : 5'd0, e.we ? e.d : 32'd0, e.hold, e.ready, e.ok, e.stall};
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got we=%0b wn=%0d d=%h hold=%0b rdy=%0b ok=%0b stall=%0b | want we=%0b wn=%0d d=%h hold=%0b rdy=%0b ok=%0b stall=%0b",
                  name, rf_we, rf_wn, rf_d, wb_hold, md_ready, iss_ok, id_stall,
                  e.we, e.wn, e.d, e.hold, e.ready, e.ok, e.stall);
      end
   endtask

   task automatic apply_chk(input string name, input vin_t v, input vex_t e);
      @(negedge Clk);
      drive(v);
      #1;
      check(name, e);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      drive(idle_in(0));
      Clrn = 1'b0;
      @(negedge Clk);
      Clrn = 1'b1;
   endtask

   // ---------------- reference model ----------------
   // exp_q holds {wn,d} of results waiting for the port, oldest first.
   logic [36:0] exp_q[$];
   bit   [31:0] m_pend;
   int          m_starve;

   task automatic model_reset();
      exp_q.delete();
      m_pend   = '0;
      m_starve = 0;
   endtask

   function automatic vex_t model_out(input vin_t v);
      vex_t        e;
      bit          ne, hold, win;
      logic [36:0] h;
      e    = '0;
      ne   = (exp_q.size() != 0);
      hold = ne && (m_starve == STARVE_MAX);
      win  = !hold && v.wb_we && (v.wb_wn != 0);
      e.hold  = hold;
      e.ready = (exp_q.size() < DEPTH);
      if (win) begin
         e.we = 1'b1; e.wn = v.wb_wn; e.d = v.wb_d;
      end else if (ne) begin
         h = exp_q[0];
         if (h[36:32] != 0) begin
            e.we = 1'b1; e.wn = h[36:32]; e.d = h[31:0];
         end
      end
      e.stall = m_pend[v.id_ra] | m_pend[v.id_rb] | m_pend[v.id_wn];
      e.ok    = !m_pend[v.iss_wn] && ($countones(m_pend) < DEPTH);
      return e;
   endfunction

   task automatic model_step(input vin_t v);
      bit          ne, hold, win, ready;
      logic [36:0] h;
      ne    = (exp_q.size() != 0);
      hold  = ne && (m_starve == STARVE_MAX);
      win   = !hold && v.wb_we && (v.wb_wn != 0);
      ready = (exp_q.size() < DEPTH);
      if (ne && !win) begin
         h = exp_q.pop_front();
         m_pend[h[36:32]] = 1'b0;
         m_starve = 0;
      end else if (ne) begin
         m_starve++;
      end
      if (v.md_valid && ready) exp_q.push_back({v.md_wn, v.md_d});
      if (v.iss_valid && v.iss_wn != 0) m_pend[v.iss_wn] = 1'b1;
      m_pend[0] = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   vec_t tbl[$];

   initial begin
      vin_t v;
      vex_t e;
      total = 0;
      bad   = 0;

      // Reset with traffic on every input: nothing may leak out.
      Clrn = 1'b0;
      drive(mk_in(1, 7, 32'h77, 1, 3, 32'h33, 1, 5, 5, 5, 5));
      #3;
      check("reset_out", mk_ex(0, 0, 0, 0, 1, 1, 0));
      @(negedge Clk);
      drive(idle_in(0));
      Clrn = 1'b1;

      // Starvation, r0 drops, and FIFO-full table.
      tbl.push_back('{mk_in(1,7,32'h70,1,3,32'hA5A5A5A5,0,0,0,0,0), mk_ex(1,7,32'h70,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h71,0,0,0,0,0,0,0,0),            mk_ex(1,7,32'h71,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h72,0,0,0,0,0,0,0,0),            mk_ex(1,7,32'h72,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h73,0,0,0,0,0,0,0,0),            mk_ex(1,7,32'h73,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h74,0,0,0,0,0,0,0,0),            mk_ex(1,7,32'h74,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h75,0,0,0,0,0,0,0,0),            mk_ex(1,3,32'hA5A5A5A5,1,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h76,1,2,32'h22222222,0,0,0,0,0), mk_ex(1,7,32'h76,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h77,0,0,0,0,0,0,0,0),            mk_ex(1,7,32'h77,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h78,0,0,0,0,0,0,0,0),            mk_ex(1,7,32'h78,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h79,0,0,0,0,0,0,0,0),            mk_ex(1,7,32'h79,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h7A,0,0,0,0,0,0,0,0),            mk_ex(1,7,32'h7A,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h7B,0,0,0,0,0,0,0,0),            mk_ex(1,2,32'h22222222,1,1,1,0)});
      tbl.push_back('{mk_in(1,0,32'hDEAD,1,0,32'h99,0,0,0,0,0),     mk_ex(0,0,0,0,1,1,0)});
      tbl.push_back('{mk_in(1,0,32'hDEAD,1,6,32'h66,0,0,0,0,0),     mk_ex(0,0,0,0,1,1,0)});
      tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,0,0,0),                 mk_ex(1,6,32'h66,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h80,1,10,32'hAA,0,0,0,0,0),      mk_ex(1,7,32'h80,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h81,1,11,32'hBB,0,0,0,0,0),      mk_ex(1,7,32'h81,0,1,1,0)});
      tbl.push_back('{mk_in(1,7,32'h82,1,12,32'hCC,0,0,0,0,0),      mk_ex(1,7,32'h82,0,0,1,0)});
      tbl.push_back('{mk_in(0,0,0,1,12,32'hCC,0,0,0,0,0),           mk_ex(1,10,32'hAA,0,0,1,0)});
      tbl.push_back('{mk_in(0,0,0,1,12,32'hCC,0,0,0,0,0),           mk_ex(1,11,32'hBB,0,1,1,0)});
      tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,0,0,0),                 mk_ex(1,12,32'hCC,0,1,1,0)});
      tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,0,0,0),                 mk_ex(0,0,0,0,1,1,0)});
      foreach (tbl[i]) begin
         apply_chk($sformatf("tbl[%0d]", i), tbl[i].vi, tbl[i].ve);
      end

      // RAW stall on r5 until its MDU result is written.
      apply_chk("raw_iss",   mk_in(0,0,0,0,0,0,1,5,0,0,0),              mk_ex(0,0,0,0,1,1,0));
      apply_chk("raw_ra",    mk_in(0,0,0,0,0,0,0,5,5,0,0),              mk_ex(0,0,0,0,1,0,1));
      apply_chk("raw_rb",    mk_in(0,0,0,0,0,0,0,5,0,5,0),              mk_ex(0,0,0,0,1,0,1));
      apply_chk("raw_push",  mk_in(0,0,0,1,5,32'h12345678,0,0,5,0,0),   mk_ex(0,0,0,0,1,1,1));
      apply_chk("raw_write", idle_in(5),                                 mk_ex(1,5,32'h12345678,0,1,1,1));
      apply_chk("raw_clear", idle_in(5),                                 mk_ex(0,0,0,0,1,1,0));

      // Two outstanding ops fill the budget; third issue waits for a pop.
      apply_chk("out_iss8",  mk_in(0,0,0,0,0,0,1,8,0,0,0),              mk_ex(0,0,0,0,1,1,0));
      apply_chk("out_iss9",  mk_in(0,0,0,0,0,0,1,9,0,0,0),              mk_ex(0,0,0,0,1,1,0));
      apply_chk("out_full",  mk_in(0,0,0,0,0,0,0,10,0,0,9),             mk_ex(0,0,0,0,1,0,1));
      apply_chk("out_md8",   mk_in(0,0,0,1,8,32'h88,0,10,0,0,0),        mk_ex(0,0,0,0,1,0,0));
      apply_chk("out_pop8",  mk_in(0,0,0,0,0,0,0,10,0,0,0),             mk_ex(1,8,32'h88,0,1,0,0));
      apply_chk("out_iss10", mk_in(0,0,0,0,0,0,1,10,0,0,0),             mk_ex(0,0,0,0,1,1,0));
      apply_chk("out_md9",   mk_in(0,0,0,1,9,32'h99,0,0,0,0,0),         mk_ex(0,0,0,0,1,0,0));
      apply_chk("out_md10",  mk_in(0,0,0,1,10,32'h1010,0,0,0,0,0),      mk_ex(1,9,32'h99,0,1,0,0));
      apply_chk("out_pop10", idle_in(0),                                 mk_ex(1,10,32'h1010,0,1,1,0));
      apply_chk("out_idle",  idle_in(0),                                 mk_ex(0,0,0,0,1,1,0));

      // Same-cycle retire and reissue of r4: set wins.
      apply_chk("sw_iss4",   mk_in(0,0,0,0,0,0,1,4,0,0,0),              mk_ex(0,0,0,0,1,1,0));
      apply_chk("sw_md4",    mk_in(0,0,0,1,4,32'h44,0,0,0,0,0),         mk_ex(0,0,0,0,1,1,0));
      apply_chk("sw_both",   mk_in(0,0,0,0,0,0,1,4,0,0,0),              mk_ex(1,4,32'h44,0,1,0,0));
      apply_chk("sw_stall",  idle_in(4),                                 mk_ex(0,0,0,0,1,1,1));
      apply_chk("sw_md4b",   mk_in(0,0,0,1,4,32'h4444,0,0,4,0,0),       mk_ex(0,0,0,0,1,1,1));
      apply_chk("sw_pop4b",  idle_in(4),                                 mk_ex(1,4,32'h4444,0,1,1,1));
      apply_chk("sw_clear",  idle_in(4),                                 mk_ex(0,0,0,0,1,1,0));

      // Reset in the middle of queued and pending work.
      apply_chk("mr_load",   mk_in(1,7,32'h700,1,13,32'hD13,1,6,0,0,0), mk_ex(1,7,32'h700,0,1,1,0));
      apply_chk("mr_pend",   mk_in(1,7,32'h701,0,0,0,0,0,6,0,0),        mk_ex(1,7,32'h701,0,1,1,1));
      @(negedge Clk);
      drive(mk_in(1,7,32'h702,1,14,32'hE14,0,6,6,0,0));
      #1;
      Clrn = 1'b0;
      #1;
      check("mr_in_reset", mk_ex(0,0,0,0,1,1,0));
      @(negedge Clk);
      drive(idle_in(6));
      Clrn = 1'b1;
      apply_chk("mr_after",  idle_in(6),                                 mk_ex(0,0,0,0,1,1,0));

      // Random traffic against the reference model.
      do_reset();
      model_reset();
      for (int c = 0; c < 800; c++) begin
         @(negedge Clk);
         v.wb_we     = ($urandom_range(0, 99) < 60);
         v.wb_wn     = 5'($urandom_range(0, 7));
         v.wb_d      = $urandom;
         v.md_valid  = ($urandom_range(0, 99) < 35);
         v.md_wn     = 5'($urandom_range(0, 7));
         v.md_d      = $urandom;
         v.iss_valid = 1'b0;
         v.iss_wn    = 5'($urandom_range(0, 7));
         v.id_ra     = 5'($urandom_range(0, 7));
         v.id_rb     = 5'($urandom_range(0, 7));
         v.id_wn     = 5'($urandom_range(0, 7));
         e = model_out(v);
         if (e.ok && ($urandom_range(0, 99) < 40)) v.iss_valid = 1'b1;
         drive(v);
         #1;
         check($sformatf("rand[%0d]", c), model_out(v));
         model_step(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
